// File: rtl/stack_pkg.sv
// Shared helpers for the LIFO stack and its storage array.
// Purpose : derives the storage depth and the occupancy-pointer width
//           from the address width W, so that every file sizes its
//           state the same way.
// Contents: depth_f(w) -> number of entries, 2**w
//           ptr_w_f(w) -> occupancy pointer width, w+1 (counts 0..2**w)
package stack_pkg;

    function automatic int depth_f(input int w);
        return 1 << w;
    endfunction

    function automatic int ptr_w_f(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/stack_regfile.sv
// Storage array for the stack: 2**W entries of B bits.
// Ports:
//   clk   in   write clock (rising edge)
//   we    in   write enable
//   waddr in   W-bit write address
//   wdata in   B-bit write data
//   raddr in   W-bit read address
//   rdata out  B-bit read data, combinational (no read latency)
// Contents are not reset; the owner gates reads of unwritten entries.
module stack_regfile
    import stack_pkg::*;
#(
    parameter int B = 8,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         we,
    input  logic [W-1:0] waddr,
    input  logic [B-1:0] wdata,
    input  logic [W-1:0] raddr,
    output logic [B-1:0] rdata
);

    localparam int DEPTH = depth_f(W);

    logic [B-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/stack.sv
// Synchronous LIFO stack with a continuously visible top-of-stack.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-high reset (empties the stack)
//   push   in   push strobe; w_data stored on the edge when accepted
//   pop    in   pop strobe; top entry dropped on the edge when accepted
//   w_data in   B-bit data to push
//   r_data out  current top-of-stack, zero when empty
//   full   out  stack holds 2**W entries
//   empty  out  stack holds no entries
// Overflow pushes and underflow pops are dropped silently. Push and pop
// together on a non-empty stack overwrite the top entry in place.
module stack
    import stack_pkg::*;
#(
    parameter int B = 8,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [B-1:0] w_data,
    output logic [B-1:0] r_data,
    output logic         full,
    output logic         empty
);

    localparam int                PTR_W    = ptr_w_f(W);
    localparam logic [PTR_W-1:0]  PTR_FULL = PTR_W'(depth_f(W));
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [W-1:0]      ADDR_ONE = W'(1);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             push_ok, pop_ok, replace;
    logic             we;
    logic [W-1:0]     waddr;
    logic [W-1:0]     top_addr;
    logic [B-1:0]     top_data;

    assign empty = (ptr_q == '0);
    assign full  = (ptr_q == PTR_FULL);

    // Both strobes on an empty stack degrade to a plain push.
    assign push_ok = push && ((!pop && !full) || (pop && empty));
    assign pop_ok  = pop && !push && !empty;
    assign replace = push && pop && !empty;

    // When full the low W bits of ptr wrap to zero, so subtracting one in
    // W bits still lands on the last entry.
    assign top_addr = ptr_q[W-1:0] - ADDR_ONE;

    // A plain push is only accepted below full, where the low bits of ptr
    // are the next free slot.
    assign we    = push_ok || replace;
    assign waddr = replace ? top_addr : ptr_q[W-1:0];

    always_comb begin
        ptr_d = ptr_q;
        if (push_ok) begin
            ptr_d = ptr_q + PTR_ONE;
        end else if (pop_ok) begin
            ptr_d = ptr_q - PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    stack_regfile #(
        .B (B),
        .W (W)
    ) u_regfile (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (w_data),
        .raddr (top_addr),
        .rdata (top_data)
    );

    // Storage is never reset, so an empty stack must not expose stale data.
    assign r_data = empty ? '0 : top_data;

endmodule

// File: tb/tb_stack.sv
module tb_stack;

    localparam int B     = 8;
    localparam int W     = 4;
    localparam int DEPTH = 16;

    logic         clk;
    logic         reset;
    logic         push;
    logic         pop;
    logic [B-1:0] w_data;
    logic [B-1:0] r_data;
    logic         full;
    logic         empty;

    stack #(.B(B), .W(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .w_data (w_data),
        .r_data (r_data),
        .full   (full),
        .empty  (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic         e;
        logic         f;
        logic [B-1:0] d;
        string        tag;
    } exp_t;

    exp_t         exp_q[$];
    logic [B-1:0] model[$];
    event         chk_ev;
    int           tests = 0;
    int           fails = 0;

    // Reference stack: a queue whose back is the top entry.
    function automatic void model_op(input logic p, input logic q, input logic [B-1:0] d);
        if (p && q) begin
            if (model.size() > 0) model[model.size()-1] = d;
            else                  model.push_back(d);
        end else if (p) begin
            if (model.size() < DEPTH) model.push_back(d);
        end else if (q) begin
            if (model.size() > 0) void'(model.pop_back());
        end
    endfunction

    function automatic void expect_now(input string tag);
        exp_t x;
        x.e   = (model.size() == 0);
        x.f   = (model.size() == DEPTH);
        x.d   = (model.size() == 0) ? '0 : model[model.size()-1];
        x.tag = tag;
        exp_q.push_back(x);
    endfunction

    // One clock of stimulus; the expected post-edge state is queued.
    task automatic step(input logic rst_v, input logic p, input logic q,
                        input logic [B-1:0] d, input string tag);
        @(negedge clk);
        reset  = rst_v;
        push   = p;
        pop    = q;
        w_data = d;
        @(posedge clk);
        if (rst_v) model.delete();
        else       model_op(p, q, d);
        expect_now(tag);
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic mid_reset(input string tag);
        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        model.delete();
        #1;
        expect_now(tag);
        ->chk_ev;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: compares every queued expectation against the DUT outputs.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk or chk_ev);
            while (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                tests++;
                if (empty !== x.e) begin
                    fails++;
                    $display("FAIL %s empty: got %b expected %b at %0t", x.tag, empty, x.e, $time);
                end
                tests++;
                if (full !== x.f) begin
                    fails++;
                    $display("FAIL %s full: got %b expected %b at %0t", x.tag, full, x.f, $time);
                end
                tests++;
                if (r_data !== x.d) begin
                    fails++;
                    $display("FAIL %s r_data: got %h expected %h at %0t", x.tag, r_data, x.d, $time);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pp, pq;
        reset  = 1'b1;
        push   = 1'b0;
        pop    = 1'b0;
        w_data = '0;

        // Reset held two cycles with a push attempted.
        step(1'b1, 1'b1, 1'b0, 8'hA5, "rst0");
        step(1'b1, 1'b1, 1'b0, 8'hA5, "rst1");
        step(1'b0, 1'b0, 1'b0, 8'h00, "idle");

        // Basic push/pop ordering.
        step(1'b0, 1'b1, 1'b0, 8'h24, "push24");
        step(1'b0, 1'b1, 1'b0, 8'h81, "push81");
        step(1'b0, 1'b1, 1'b0, 8'h09, "push09");
        step(1'b0, 1'b0, 1'b1, 8'h00, "pop1");
        step(1'b0, 1'b0, 1'b1, 8'h00, "pop2");

        // Fill to full, then overflow.
        mid_reset("clr");
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, B'(i), "fill");
        step(1'b0, 1'b1, 1'b0, 8'hAA, "overflow");

        // Drain to empty, then underflow.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, 8'h00, "drain");
        step(1'b0, 1'b0, 1'b1, 8'h00, "underflow");
        step(1'b0, 1'b1, 1'b0, 8'h77, "post_uflow");
        step(1'b0, 1'b0, 1'b1, 8'h00, "post_uflow_pop");

        // Replace-top and push+pop on empty.
        step(1'b0, 1'b1, 1'b0, 8'h11, "push11");
        step(1'b0, 1'b1, 1'b0, 8'h22, "push22");
        step(1'b0, 1'b1, 1'b1, 8'h33, "replace33");
        step(1'b0, 1'b0, 1'b1, 8'h00, "pop_after_repl");
        step(1'b0, 1'b0, 1'b1, 8'h00, "pop_to_empty");
        step(1'b0, 1'b1, 1'b1, 8'h44, "pp_empty44");

        // Replace while full.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 8'hC0 + B'(i), "refill");
        step(1'b0, 1'b1, 1'b1, 8'h5A, "replace_full");
        step(1'b0, 1'b0, 1'b1, 8'h00, "pop_after_rfull");

        // Asynchronous reset mid-cycle with 5 entries, then push.
        mid_reset("clr2");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'h60 + B'(i), "push5");
        mid_reset("async_rst");
        step(1'b0, 1'b1, 1'b0, 8'h55, "push55");

        // Randomized phases: push-heavy, pop-heavy, balanced.
        for (int ph = 0; ph < 12; ph++) begin
            case (ph % 3)
                0:       begin pp = 80; pq = 20; end
                1:       begin pp = 20; pq = 80; end
                default: begin pp = 50; pq = 50; end
            endcase
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(0, 199) == 0) begin
                    mid_reset("rand_rst");
                end else begin
                    step(1'b0,
                         ($urandom_range(0, 99) < pp),
                         ($urandom_range(0, 99) < pq),
                         B'($urandom), "rand");
                end
            end
        end

        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stack.md
Name: stack

Overview:
- Synchronous LIFO stack with parameterised data width and depth (2**W entries).
- Top-of-stack is presented continuously on r_data; push/pop are single-cycle strobes.
- Used as a generic local storage primitive (return-address / operand stacks) inside larger datapaths.

Parameters:
- B, 8, data width in bits.
- W, 4, address width; depth = 2**W entries (default 16).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- push  in  1  push strobe; w_data is written on the rising edge when accepted.
- pop  in  1  pop strobe; top entry is removed on the rising edge when accepted.
- w_data  in  B  data to push.
- r_data  out  B  current top-of-stack value.
- full  out  1  high when the stack holds 2**W entries.
- empty  out  1  high when the stack holds 0 entries.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port named reset.
- State: occupancy pointer ptr, W+1 bits, range 0..2**W. Storage is 2**W x B. Storage is not reset.
- Reset: ptr=0, so empty=1, full=0, r_data=0. Applies immediately and overrides any push/pop in flight.
- Flags are combinational from ptr: empty = (ptr==0), full = (ptr==2**W).
- r_data is combinational: mem[ptr-1] when not empty, else all zeros. There is no read latency; after the clock edge of a push or pop, r_data reflects the new top in the same cycle.
- Push only (push=1, pop=0):
  - If not full: mem[ptr] <= w_data; ptr <= ptr+1.
  - If full: ignored; no write, no pointer change.
- Pop only (push=0, pop=1):
  - If not empty: ptr <= ptr-1.
  - If empty: ignored.
- Push and pop together:
  - If not empty: replace the top, mem[ptr-1] <= w_data; ptr unchanged. This applies even when full.
  - If empty: treated as push only.
- No error flags; overflow and underflow attempts are silently dropped.

Decomposition:
- Shared package stack_pkg:
  - Localparam DEPTH = 2**W helper function.
  - Pointer-width function (W+1).
- Natural sub-module: stack_regfile.
  - 2**W x B array with synchronous write (we, waddr, wdata) and asynchronous read (raddr, rdata).
- Top level holds the pointer, the accept logic (push_ok/pop_ok/replace), the flags and the r_data zero-gating.

Test Plan:
- Reset for 2 cycles -> empty=1, full=0, r_data=00; push during reset is ignored.
- Push 8'h24, 8'h81, 8'h09 on consecutive cycles, then pop twice -> r_data sequence after each edge: 24, 81, 09, 81, 24; final empty=0, full=0, r_data=24.
- Push 16 values 8'h00..8'h0F -> full=1 after the 16th, r_data=0F. A 17th push of 8'hAA is ignored: r_data stays 0F, full stays 1.
- From full, pop 16 times -> r_data steps 0E..00, then empty=1, r_data=00. A further pop is ignored; ptr stays 0.
- With stack holding [11,22] (top 22), assert push+pop with w_data=8'h33 -> r_data=33, occupancy unchanged. Pop once -> r_data=11. On an empty stack, push+pop with 8'h44 -> r_data=44, empty=0.
- Assert reset asynchronously mid-cycle with 5 entries held -> empty=1, r_data=00 immediately, before the next clock edge. A following push of 8'h55 -> r_data=55.
